// File: rtl/eth_pcs_rx_block_sync.sv
// 64b/66b receive block synchronizer: hunts for sync-header alignment by slipping the
// gearbox, declares lock after SH_TH good headers and drops lock on SH_INVAL_TH bad headers per window.
module eth_pcs_rx_block_sync #(
    parameter int SH_TH       = 64,
    parameter int SH_INVAL_TH = 16,
    parameter int SLIP_WAIT   = 4,
    parameter int W_SYNC      = 2,
    parameter int W_PLD_BLK   = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    input  logic [W_SYNC-1:0]    i_sync,
    input  logic [W_PLD_BLK-1:0] i_data,
    output logic                 o_slip,
    output logic                 o_block_lock,
    output logic                 o_valid,
    output logic [W_SYNC-1:0]    o_sync,
    output logic [W_PLD_BLK-1:0] o_data,
    output logic                 o_sh_err
);

    localparam int SH_W   = (SH_TH > 1)       ? $clog2(SH_TH)       : 1;
    localparam int INV_W  = (SH_INVAL_TH > 1) ? $clog2(SH_INVAL_TH) : 1;
    localparam int WAIT_W = (SLIP_WAIT > 1)   ? $clog2(SLIP_WAIT)   : 1;

    // Terminal counts: the Nth event is recognised while the count still reads N-1.
    localparam logic [SH_W-1:0]   SH_LAST   = SH_W'(SH_TH - 1);
    localparam logic [INV_W-1:0]  INV_LAST  = INV_W'(SH_INVAL_TH - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

    localparam logic [W_SYNC-1:0] SYNC_DATA = W_SYNC'(1);
    localparam logic [W_SYNC-1:0] SYNC_CTRL = W_SYNC'(2);

    typedef enum logic [1:0] {
        UNLOCKED,
        LOCKED,
        SLIP_HOLD
    } state_t;

    state_t            state;
    logic [SH_W-1:0]   sh_cnt;
    logic [INV_W-1:0]  inv_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              sh_ok;

    assign sh_ok = (i_sync == SYNC_DATA) || (i_sync == SYNC_CTRL);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= UNLOCKED;
            sh_cnt       <= '0;
            inv_cnt      <= '0;
            wait_cnt     <= '0;
            o_slip       <= 1'b0;
            o_block_lock <= 1'b0;
            o_valid      <= 1'b0;
            o_sh_err     <= 1'b0;
            o_sync       <= '0;
            o_data       <= '0;
        end else begin
            o_slip   <= 1'b0;
            o_valid  <= 1'b0;
            o_sh_err <= 1'b0;
            if (i_valid) begin
                o_sync   <= i_sync;
                o_data   <= i_data;
                o_valid  <= (state == LOCKED);
                o_sh_err <= !sh_ok && (state != SLIP_HOLD);
                case (state)
                    UNLOCKED: begin
                        if (sh_ok) begin
                            if (sh_cnt == SH_LAST) begin
                                state        <= LOCKED;
                                o_block_lock <= 1'b1;
                                sh_cnt       <= '0;
                                inv_cnt      <= '0;
                            end else begin
                                sh_cnt <= sh_cnt + 1'b1;
                            end
                        end else begin
                            state    <= SLIP_HOLD;
                            o_slip   <= 1'b1;
                            sh_cnt   <= '0;
                            inv_cnt  <= '0;
                            wait_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        // Loss of lock is tested first so it wins over a coincident window end.
                        if (!sh_ok && (inv_cnt == INV_LAST)) begin
                            state        <= SLIP_HOLD;
                            o_block_lock <= 1'b0;
                            o_slip       <= 1'b1;
                            sh_cnt       <= '0;
                            inv_cnt      <= '0;
                            wait_cnt     <= '0;
                        end else if (sh_cnt == SH_LAST) begin
                            sh_cnt  <= '0;
                            inv_cnt <= '0;
                        end else begin
                            sh_cnt <= sh_cnt + 1'b1;
                            if (!sh_ok) begin
                                inv_cnt <= inv_cnt + 1'b1;
                            end
                        end
                    end
                    SLIP_HOLD: begin
                        if (wait_cnt == WAIT_LAST) begin
                            state    <= UNLOCKED;
                            sh_cnt   <= '0;
                            inv_cnt  <= '0;
                            wait_cnt <= '0;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state    <= UNLOCKED;
                        sh_cnt   <= '0;
                        inv_cnt  <= '0;
                        wait_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_eth_pcs_rx_block_sync.sv
// Scoreboard bench for eth_pcs_rx_block_sync: directed beats push hand-derived expectations,
// a monitor pops one entry per cycle and compares all outputs.
module tb_eth_pcs_rx_block_sync;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic [1:0]  i_sync;
    logic [63:0] i_data;
    logic        o_slip;
    logic        o_block_lock;
    logic        o_valid;
    logic [1:0]  o_sync;
    logic [63:0] o_data;
    logic        o_sh_err;

    eth_pcs_rx_block_sync #(
        .SH_TH      (64),
        .SH_INVAL_TH(16),
        .SLIP_WAIT  (4),
        .W_SYNC     (2),
        .W_PLD_BLK  (64)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_valid     (i_valid),
        .i_sync      (i_sync),
        .i_data      (i_data),
        .o_slip      (o_slip),
        .o_block_lock(o_block_lock),
        .o_valid     (o_valid),
        .o_sync      (o_sync),
        .o_data      (o_data),
        .o_sh_err    (o_sh_err)
    );

    typedef struct {
        logic        slip;
        logic        lock;
        logic        valid;
        logic        err;
        logic [1:0]  sync;
        logic [63:0] data;
        string       tag;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [1:0]  last_sync;
    logic [63:0] last_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (!rst && q.size() > 0) begin
            mon_e = q.pop_front();
            n_checks++;
            if (o_slip !== mon_e.slip || o_block_lock !== mon_e.lock || o_valid !== mon_e.valid ||
                o_sh_err !== mon_e.err || o_sync !== mon_e.sync || o_data !== mon_e.data) begin
                n_fail++;
                $display("FAIL %s: got slip=%0b lock=%0b valid=%0b err=%0b sync=%0h data=%h, expected slip=%0b lock=%0b valid=%0b err=%0b sync=%0h data=%h",
                         mon_e.tag, o_slip, o_block_lock, o_valid, o_sh_err, o_sync, o_data,
                         mon_e.slip, mon_e.lock, mon_e.valid, mon_e.err, mon_e.sync, mon_e.data);
            end
        end
    end

    task automatic beat(input logic v, input logic [1:0] s, input logic e_slip, input logic e_lock,
                        input logic e_valid, input logic e_err, input string tag);
        exp_t        e;
        logic [63:0] d;
        d = {$urandom, $urandom};
        @(negedge clk);
        i_valid = v;
        i_sync  = s;
        i_data  = d;
        if (v) begin
            last_sync = s;
            last_data = d;
        end
        e.slip  = e_slip;
        e.lock  = e_lock;
        e.valid = e_valid;
        e.err   = e_err;
        e.sync  = last_sync;
        e.data  = last_data;
        e.tag   = tag;
        q.push_back(e);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_drain: got %0d pending entries, expected 0", tag, q.size());
            q.delete();
        end
    endtask

    task automatic check_zero(input string tag);
        n_checks++;
        if ({o_slip, o_block_lock, o_valid, o_sh_err} !== 4'b0 || o_sync !== 2'b0 || o_data !== 64'b0) begin
            n_fail++;
            $display("FAIL %s: got slip=%0b lock=%0b valid=%0b err=%0b sync=%0h data=%h, expected all zero",
                     tag, o_slip, o_block_lock, o_valid, o_sh_err, o_sync, o_data);
        end
    endtask

    // Reset is asserted mid-cycle so the outputs must clear without a clock edge.
    task automatic do_reset(input string tag);
        drain(tag);
        @(negedge clk);
        i_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_zero(tag);
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        last_sync = 2'b00;
        last_data = 64'b0;
    endtask

    task automatic lock_up(input string tag);
        for (int k = 1; k <= 64; k++)
            beat(1'b1, (k % 3 == 0) ? 2'b10 : 2'b01, 1'b0, k == 64, 1'b0, 1'b0, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        i_valid   = 1'b0;
        i_sync    = 2'b00;
        i_data    = 64'b0;
        last_sync = 2'b00;
        last_data = 64'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_state");
        @(negedge clk);
        rst = 1'b0;

        // Plain acquisition: lock after beat 64, first forward after beat 65.
        lock_up("acquire");
        beat(1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, "first_forward");
        do_reset("rst_after_acquire");

        // Bad header on beat 10 while hunting.
        for (int k = 1; k <= 9; k++)
            beat(1'b1, k[0] ? 2'b01 : 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, "hunt_pre_err");
        beat(1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, "hunt_err_slip");
        for (int k = 1; k <= 4; k++)
            beat(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, "slip_hold_ignore");
        lock_up("relock_after_slip");

        // Two windows with 15 bad headers each: lock held, window restart clears the count.
        for (int w = 0; w < 2; w++)
            for (int k = 1; k <= 64; k++)
                beat(1'b1, (k <= 15) ? (k[0] ? 2'b11 : 2'b00) : 2'b10,
                     1'b0, 1'b1, 1'b1, k <= 15, "win_15_bad");

        // 16th bad header lands on window beat 64: loss of lock wins.
        for (int k = 1; k <= 64; k++)
            beat(1'b1, (k >= 49) ? 2'b00 : 2'b01, k == 64, k != 64, 1'b1, k >= 49, "win_16th_on_last");
        for (int k = 1; k <= 4; k++)
            beat(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, "hold_after_loss");

        // Valid beats interleaved with idle cycles carrying bad headers.
        for (int k = 1; k <= 64; k++) begin
            beat(1'b1, 2'b01, 1'b0, k == 64, 1'b0, 1'b0, "toggle_valid");
            beat(1'b0, 2'b00, 1'b0, k == 64, 1'b0, 1'b0, "toggle_idle");
        end

        // Reset while locked at window beat 30.
        for (int k = 1; k <= 29; k++)
            beat(1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, "locked_pre_rst");
        do_reset("rst_while_locked");
        lock_up("relock_after_rst");

        // Reset in the middle of a slip hold.
        do_reset("rst_before_hold");
        beat(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, "slip_before_rst");
        beat(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, "hold_before_rst");
        beat(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, "hold_before_rst");
        do_reset("rst_mid_hold");
        lock_up("relock_after_hold_rst");

        drain("final");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_pcs_rx_block_sync.md
ETH_PCS_RX_BLOCK_SYNC -- requirements
Module: eth_pcs_rx_block_sync

Interface
REQ-001 SHALL have parameter SH_TH, default 64, valid sync headers required for lock and lock-mode window length.
REQ-002 SHALL have parameter SH_INVAL_TH, default 16, invalid headers within one window that cause loss of lock.
REQ-003 SHALL have parameter SLIP_WAIT, default 4, i_valid beats ignored after each slip request.
REQ-004 SHALL have port i_clk  input  1  single clock; every register clocks on its rising edge.
REQ-005 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port i_valid  input  1  one 66-bit block (sync + payload) presented by the RX gearbox this cycle.
REQ-007 SHALL have port i_sync  input  W_SYNC  received sync header.
REQ-008 SHALL have port i_data  input  W_PLD_BLK  received payload.
REQ-009 SHALL have port o_slip  output  1  one-cycle request to the RX gearbox to shift alignment by one bit.
REQ-010 SHALL have port o_block_lock  output  1  block lock achieved.
REQ-011 SHALL have port o_valid  output  1  locked block forwarded to the decoder.
REQ-012 SHALL have port o_sync  output  W_SYNC  registered i_sync.
REQ-013 SHALL have port o_data  output  W_PLD_BLK  registered i_data.
REQ-014 SHALL have port o_sh_err  output  1  one-cycle pulse, invalid header seen.

Function
REQ-015 Valid header SHALL mean i_sync == SYNC_DATA or SYNC_CTRL; 2'b00 and 2'b11 are invalid.
REQ-016 All decisions SHALL occur only on cycles with i_valid=1; with i_valid=0, state, counters and o_block_lock hold; o_slip, o_valid, o_sh_err = 0.
REQ-017 FSM states SHALL be UNLOCKED, LOCKED, SLIP_HOLD.
REQ-018 sh_cnt SHALL be clog2(SH_TH) bits, inv_cnt clog2(SH_INVAL_TH) bits; the Nth event is detected by comparing the count to N-1 before increment, never by overflow.
REQ-019 UNLOCKED, valid header: sh_cnt++; on the SH_TH-th consecutive valid header -> LOCKED, o_block_lock=1 next cycle, counters cleared.
REQ-020 UNLOCKED, invalid header: o_slip=1 next cycle (one cycle), counters cleared -> SLIP_HOLD.
REQ-021 SLIP_HOLD: count SLIP_WAIT i_valid beats (headers ignored, no o_sh_err), then -> UNLOCKED with counters cleared.
REQ-022 LOCKED: each valid beat increments sh_cnt; each invalid header increments inv_cnt.
REQ-023 LOCKED, SH_INVAL_TH-th invalid header in current window -> o_block_lock=0, o_slip pulse, counters cleared -> SLIP_HOLD.
REQ-024 LOCKED, SH_TH-th beat of window without reaching SH_INVAL_TH -> both counters cleared, remain LOCKED.
REQ-025 Simultaneous SH_INVAL_TH-th invalid and SH_TH-th beat: loss of lock SHALL take priority.
REQ-026 o_valid SHALL be registered i_valid AND (state==LOCKED before update), latency 1 cycle; the beat causing lock is not forwarded, the beat causing loss is forwarded.
REQ-027 o_sync/o_data SHALL register i_sync/i_data on every i_valid beat, latency 1, holding otherwise.
REQ-028 o_sh_err SHALL be registered (i_valid AND invalid header AND state!=SLIP_HOLD).
REQ-029 o_slip SHALL never be asserted on two consecutive cycles.

Reset
REQ-030 i_rst=1 SHALL asynchronously force state UNLOCKED, counters 0, and all outputs 0 (o_slip, o_block_lock, o_valid, o_sh_err, o_sync, o_data).
REQ-031 Reset asserted mid-window or mid-SLIP_HOLD SHALL abandon progress; after release, lock requires a fresh SH_TH valid headers.

Verification
REQ-032 64 consecutive i_valid beats with i_sync=2'b01 after reset -> o_block_lock rises the cycle after beat 64; o_valid first high after beat 65; o_slip never asserted.
REQ-033 Unlocked, beat 10 has i_sync=2'b11 -> o_sh_err and o_slip high for exactly one cycle after beat 10; next 4 beats ignored; lock requires 64 further valid beats.
REQ-034 Locked, 15 invalid headers within one 64-beat window -> lock held, 15 o_sh_err pulses, no o_slip; counters cleared at window end.
REQ-035 Locked, 16th invalid header on beat 64 of window -> o_block_lock falls and o_slip pulses the next cycle (loss beats window restart).
REQ-036 i_valid toggled 1/0 every cycle with valid headers -> lock after 64 valid beats (127 cycles); idle cycles change nothing.
REQ-037 i_rst pulsed while locked at beat 30 of window -> all outputs 0 immediately, then 64 valid beats required to relock.
